// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the pipelined multiplier and
//                its result queue. MUL_LATENCY is the single source of truth
//                for the multiplier depth, so the multiplier and the queue
//                that tracks it cannot disagree.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_LATENCY   = 3;
    localparam int MUL_DATA_SIZE = 32;
    localparam int MUL_TAG_W     = 3;

    // Sideband carried alongside an op while it is inside the multiplier
    typedef struct packed {
        logic [MUL_TAG_W-1:0] tag;
        logic                 hi;
    } mul_side_t;

    // Result as stored in the writeback queue
    typedef struct packed {
        logic [MUL_TAG_W-1:0]     tag;
        logic [MUL_DATA_SIZE-1:0] data;
    } mul_entry_t;

endpackage
`default_nettype wire

// File: rtl/mul_result_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_result_queue_if
//  Description : Bundle of issue, multiplier-return and writeback signals for
//                mul_result_queue.
//                master : issue stage / multiplier / writeback arbiter side
//                slave  : the result queue itself
//  Revision    : 1.0  initial release
// ============================================================================
interface mul_result_queue_if #(
    parameter int DATA_SIZE = 32,
    parameter int TAG_W     = 3
);
    logic                   flush;
    logic                   issue_valid;
    logic [TAG_W-1:0]       issue_tag;
    logic                   issue_hi;
    logic                   issue_ready;
    logic                   mul_ready;
    logic [2*DATA_SIZE-1:0] mul_result;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [TAG_W-1:0]       wb_tag;
    logic [DATA_SIZE-1:0]   wb_data;
    logic                   err;

    modport master (
        output flush, issue_valid, issue_tag, issue_hi,
        output mul_ready, mul_result, wb_ready,
        input  issue_ready, wb_valid, wb_tag, wb_data, err
    );

    modport slave (
        input  flush, issue_valid, issue_tag, issue_hi,
        input  mul_ready, mul_result, wb_ready,
        output issue_ready, wb_valid, wb_tag, wb_data, err
    );
endinterface
`default_nettype wire

// File: rtl/mul_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mul_result_fifo
//  Description : Small circular FIFO holding multiply results until the
//                writeback arbiter takes them. Head entry comes straight from
//                registered storage.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_flush         drop all entries, reset pointers
//                i_push/i_push_data  write one entry
//                i_pop           remove head entry (ignored when empty)
//                o_head          head entry
//                o_count         occupancy 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module mul_result_fifo
    import mul_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type T_ENTRY = mul_entry_t,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_flush,
    input  wire logic       i_push,
    input  wire T_ENTRY     i_push_data,
    input  wire logic       i_pop,
    output T_ENTRY          o_head,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    T_ENTRY             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO can still accept when the head leaves in the same cycle
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mul_result_queue.sv
`default_nettype none
// ============================================================================
//  Module      : mul_result_queue
//  Description : Tracks sideband (tag, hi/lo) of ops issued to the fixed-
//                latency multiplier, captures the selected product word when
//                the op emerges, buffers it for writeback, and hands the
//                issue stage credit-based back-pressure.
//  Ports       : clk, rst_n   clock, async active-low reset
//                q_if.slave   flush, issue_valid/tag/hi, issue_ready,
//                             mul_ready, mul_result, wb_valid/ready/tag/data,
//                             err (sticky protocol error)
//  Revision    : 1.0  initial release
// ============================================================================
module mul_result_queue
    import mul_pkg::*;
#(
    parameter int DATA_SIZE = MUL_DATA_SIZE,
    parameter int TAG_W     = MUL_TAG_W,
    parameter int LATENCY   = MUL_LATENCY,
    parameter int DEPTH     = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mul_result_queue_if.slave q_if
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = $clog2(LATENCY + DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             hi;
    } side_t;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [DATA_SIZE-1:0] data;
    } entry_t;

    logic [LATENCY-1:0] r_pipe_vld;
    side_t              r_pipe_side [LATENCY];
    logic               r_err;

    side_t              w_last;
    entry_t             w_cap_entry;
    entry_t             w_head;
    logic [CNT_W-1:0]   w_count;
    logic [SUM_W-1:0]   w_credit_used;
    logic               w_issue_ready;
    logic               w_issue_ok;
    logic               w_cap;
    logic               w_pop;

    // Credits in use = ops inside the multiplier + results waiting. Built
    // from registers only, so a pop frees a credit one cycle later.
    always_comb begin
        w_credit_used = SUM_W'(w_count);
        for (int i = 0; i < LATENCY; i++) begin
            w_credit_used = w_credit_used + SUM_W'(r_pipe_vld[i]);
        end
    end

    assign w_issue_ready = (w_credit_used < SUM_W'(DEPTH));
    assign w_issue_ok    = q_if.issue_valid && w_issue_ready && !q_if.flush;
    assign w_last        = r_pipe_side[LATENCY-1];
    assign w_cap         = r_pipe_vld[LATENCY-1] && !q_if.flush;
    assign w_pop         = (w_count != '0) && q_if.wb_ready && !q_if.flush;

    assign w_cap_entry.tag  = w_last.tag;
    assign w_cap_entry.data = w_last.hi ? q_if.mul_result[2*DATA_SIZE-1:DATA_SIZE]
                                        : q_if.mul_result[DATA_SIZE-1:0];

    // Sideband pipe mirrors the multiplier: shifts every cycle, never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) r_pipe_side[i] <= '0;
        end else begin
            r_pipe_vld[0]     <= w_issue_ok;
            r_pipe_side[0]    <= '{tag: q_if.issue_tag, hi: q_if.issue_hi};
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_side[i] <= r_pipe_side[i-1];
            end
            if (q_if.flush) r_pipe_vld <= '0;
        end
    end

    // Sticky: missing multiplier result, or issue without credit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (!q_if.flush &&
                     ((r_pipe_vld[LATENCY-1] && !q_if.mul_ready) ||
                      (q_if.issue_valid && !w_issue_ready))) begin
            r_err <= 1'b1;
        end
    end

    mul_result_fifo #(
        .DEPTH   (DEPTH),
        .T_ENTRY (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (q_if.flush),
        .i_push      (w_cap),
        .i_push_data (w_cap_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign q_if.issue_ready = w_issue_ready;
    assign q_if.wb_valid    = (w_count != '0);
    assign q_if.wb_tag      = w_head.tag;
    assign q_if.wb_data     = w_head.data;
    assign q_if.err         = r_err;

endmodule
`default_nettype wire
